ps2_rx_fifo: RTL and testbench

Upstream receive stage of the keyboard path. It samples the raw PS/2 clock/data pins in the system clock domain and deframes 11-bit device-to-host frames. Valid scan-code bytes go into a small FIFO, which the scan-code analysis stage drains with an active-low pop strobe. Overflow and framing-error status are flagged for the LED/debug logic.

---
 rtl/ps2_rx_fifo_pkg.sv | 14 +
 rtl/ps2_rx_fifo_if.sv | 22 ++
 rtl/ps2_byte_fifo.sv | 60 ++++++
 rtl/ps2_rx_fifo.sv | 85 ++++++++
 tb/tb_ps2_rx_fifo.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_fifo_pkg.sv
// Shared constants for the PS/2 receive path and its downstream scan-code logic.
package ps2_rx_fifo_pkg;

    localparam int         PS2_FRAME_BITS      = 11;
    localparam logic [7:0] BREAK               = 8'hF0;
    localparam logic [7:0] EXT                 = 8'hE0;
    localparam int         DEFAULT_TIMEOUT_CYC = 100000;

    // shift[0] is the start bit, shift[8:1] the byte, shift[9] the parity bit
    function automatic logic frame_ok(input logic [9:0] shift, input logic stop);
        return (shift[0] == 1'b0) && (^shift[9:1]) && stop;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// PS/2 pin and scan-code FIFO signals; slave is the receiver, master drives pins and pops.
interface ps2_rx_fifo_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       ready;
    logic       nextdata_n;
    logic       overflow;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, nextdata_n,
        input  data, ready, overflow, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, nextdata_n,
        output data, ready, overflow, frame_err
    );

endinterface

// File: rtl/ps2_byte_fifo.sv
// Small byte FIFO with extra-MSB pointers, head read combinationally, sticky overflow.
module ps2_byte_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic                r_ovf;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign w_pop   = i_pop & ~w_empty;
    // a pop in the same cycle frees the slot the write needs
    assign w_push  = i_wr & (~w_full | w_pop);

    assign o_rdata    = r_mem[r_rptr[DEPTH_LOG2-1:0]];
    assign o_ready    = ~w_empty;
    assign o_overflow = r_ovf;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_wdata;
                r_wptr                        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_pop) begin
                r_ovf <= 1'b0;
            end else if (i_wr && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, 11-bit deframer with timeout, byte FIFO.
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2  = 3,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          clrn,
    ps2_rx_fifo_if.slave  bus
);

    localparam int         TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]       r_s;
    logic [1:0]       r_d;
    logic [3:0]       r_cnt;
    logic [9:0]       r_shift;
    logic [TMO_W-1:0] r_tmo;
    logic             r_ferr;
    logic             w_fall;
    logic             w_bit;
    logic             w_last;
    logic             w_good;
    logic             w_tmo_hit;

    assign w_fall    = r_s[2] & ~r_s[1];
    assign w_bit     = r_d[1];
    assign w_last    = w_fall && (r_cnt == LAST_BIT);
    assign w_good    = w_last && frame_ok(r_shift, w_bit);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_s <= '0;
            r_d <= '0;
        end else begin
            r_s <= {r_s[1:0], bus.ps2_clk};
            r_d <= {r_d[0], bus.ps2_data};
        end
    end

    // Bit counter, inactivity timer and sticky framing error
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt  <= '0;
            r_tmo  <= '0;
            r_ferr <= 1'b0;
        end else if (w_fall) begin
            r_tmo <= '0;
            if (w_last) begin
                r_cnt <= '0;
                if (!w_good) r_ferr <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            if (!w_tmo_hit) r_tmo <= r_tmo + 1'b1;
            if (w_tmo_hit && (r_cnt != '0)) r_cnt <= '0;
        end
    end

    // LSB-first: after ten bits the start bit has shifted down to [0]
    always_ff @(posedge clk) begin
        if (w_fall && !w_last) r_shift <= {w_bit, r_shift[9:1]};
    end

    ps2_byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (8)
    ) u_fifo (
        .clk        (clk),
        .clrn       (clrn),
        .i_wr       (w_good),
        .i_wdata    (r_shift[8:1]),
        .i_pop      (~bus.nextdata_n),
        .o_rdata    (bus.data),
        .o_ready    (bus.ready),
        .o_overflow (bus.overflow)
    );

    assign bus.frame_err = r_ferr;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo with a scaled-down PS/2 clock and timeout.
module tb_ps2_rx_fifo;
    import ps2_rx_fifo_pkg::*;

    localparam int HP  = 10;
    localparam int TMO = 100;

    logic clk  = 1'b0;
    logic clrn = 1'b0;

    ps2_rx_fifo_if bus ();

    ps2_rx_fifo #(
        .DEPTH_LOG2  (3),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         n_chk    = 0;
    int         n_err    = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf  = 1'b0;
    logic       exp_ferr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, want);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic drive_bit(input logic b);
        bus.ps2_data = b;
        repeat (HP) @(posedge clk);
        #1 bus.ps2_clk = 1'b0;
        repeat (HP) @(posedge clk);
        #1 bus.ps2_clk = 1'b1;
    endtask

    // mode 0: plain frame, 1: measure stop-fall to ready, 2: pop lands on the write edge
    task automatic send_frame(input logic [7:0] b, input logic bad, input int mode);
        logic [10:0] f;
        int          lat;
        f   = mk_frame(b, bad);
        lat = 0;
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        bus.ps2_data = f[10];
        repeat (HP) @(posedge clk);
        #1 bus.ps2_clk = 1'b0;
        if (mode == 1) begin
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                @(posedge clk);
                #1;
                if (bus.ready) lat = k;
            end
            chk("latency_3to5", 32'(lat >= 3 && lat <= 5), 1);
        end else if (mode == 2) begin
            repeat (2) @(posedge clk);
            #1;
            chk("coincide_head", bus.data, exp_q[0]);
            bus.nextdata_n = 1'b0;
            @(posedge clk);
            #1 bus.nextdata_n = 1'b1;
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
        repeat (HP) @(posedge clk);
        #1 bus.ps2_clk = 1'b1;
        repeat (2 * HP) @(posedge clk);
        #1;
        if (bad)                    exp_ferr = 1'b1;
        else if (exp_q.size() < 8)  exp_q.push_back(b);
        else                        exp_ovf = 1'b1;
    endtask

    task automatic send_partial(input int n);
        logic [10:0] f;
        f = mk_frame(8'hAA, 1'b0);
        for (int i = 0; i < n; i++) drive_bit(f[i]);
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, bus.ready, 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk({tag, "_data"}, bus.data, exp_q[0]);
        chk({tag, "_ovf"}, bus.overflow, exp_ovf);
        chk({tag, "_ferr"}, bus.frame_err, exp_ferr);
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        chk({tag, "_pop_rdy"}, bus.ready, 1);
        if (exp_q.size() != 0) chk({tag, "_pop_data"}, bus.data, exp_q[0]);
        @(posedge clk);
        #1 bus.nextdata_n = 1'b0;
        @(posedge clk);
        #1 bus.nextdata_n = 1'b1;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.nextdata_n = 1'b1;
        clrn = 1'b0;
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ps2_clk    = 1'b1;
        bus.ps2_data   = 1'b1;
        bus.nextdata_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", bus.ready, 0);
        chk("rst_data", bus.data, 8'h00);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_ferr", bus.frame_err, 0);
        #1 clrn = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        send_frame(8'h1C, 1'b0, 1);
        check_status("t1");
        pop_one("t1");
        check_status("t1_after");

        send_frame(BREAK, 1'b0, 0);
        send_frame(8'h1C, 1'b0, 0);
        check_status("t2_two");
        pop_one("t2_a");
        check_status("t2_one");
        pop_one("t2_b");
        check_status("t2_empty");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0);
        check_status("t3_full");
        for (int i = 0; i < 8; i++) begin
            pop_one("t3");
            check_status("t3_drain");
        end

        send_frame(8'h5A, 1'b1, 0);
        check_status("t4_bad");
        send_frame(8'h5A, 1'b0, 0);
        check_status("t4_good");
        pop_one("t4");

        do_reset();
        send_partial(5);
        repeat (TMO + 50) @(posedge clk);
        #1;
        send_frame(8'h29, 1'b0, 0);
        check_status("t5_tmo");
        pop_one("t5_tmo");

        send_partial(5);
        do_reset();
        repeat (4) @(posedge clk);
        #1;
        send_frame(8'h29, 1'b0, 0);
        check_status("t5_rst");

        do_reset();
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 0);
        check_status("t6_full");
        send_frame(8'h18, 1'b0, 2);
        check_status("t6_coincide");
        for (int i = 0; i < 8; i++) pop_one("t6");
        check_status("t6_empty");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
